// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory access arbiter.
//   MEM_ADDR_W / MEM_DATA_W : default memory word-address and data widths
//   arb_state_t             : arbiter FSM states (IDLE, OWN0, OWN1)
//   mem_req_t               : one requester's memory beat fields
//   rd_tag_t                : read-return tag {v, id} carried through the read-latency pipe
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 17;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] a;
        logic                  we;
        logic [MEM_DATA_W-1:0] wdv;
        logic [MEM_DATA_W-1:0] wds;
        logic [1:0]            pos;
        logic                  e;
        logic                  s;
    } mem_req_t;

    typedef struct packed {
        logic v;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/mem_arb_rd_tag_pipe.sv
// Read-return tag delay line. Every cycle one tag is pushed (v=1 for an accepted read,
// v=0 otherwise); the tail emerges RD_LAT cycles later, aligned with the memory read data.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high clear of all in-flight tags
//   push : tag entering the pipe this cycle
//   tail : tag leaving the pipe (matches current MEM_RD)
module mem_arb_rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t push,
    output rd_tag_t tail
);

    rd_tag_t tag_p [RD_LAT];

    // Stage boundary: tag_p[0] is the beat accepted at the last edge, tag_p[RD_LAT-1] the oldest.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_p[i] <= '0;
            end
        end else begin
            tag_p[0] <= push;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign tail = tag_p[RD_LAT-1];

endmodule

// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter in front of the single-port MEMORY block.
// R0 = core load/store unit, R1 = host/DMA image loader. Per-cycle arbitration, locked
// bursts of up to MAX_BURST beats, and read data routed back to the issuing requester.
// Build option: define ARB_FIXED_PRIO_EN to make idle ties always go to R0 (round-robin
// pointer ignored); default is round-robin tie-break.
// Ports:
//   CLK, RST                   clock / synchronous active-high reset
//   Rn_REQ, Rn_LOCK            beat request / burst ownership request (n = 0,1)
//   Rn_A, Rn_WE, Rn_WDV, Rn_WDS, Rn_POS, Rn_E, Rn_S   beat fields, held until Rn_GNT
//   Rn_GNT                     beat accepted at this edge (combinational)
//   Rn_RVALID, Rn_RD           read-return pulse and data (Rn_RD = MEM_RD)
//   MEM_A .. MEM_S             muxed beat to MEMORY (all zero when nothing granted)
//   MEM_RD                     MEMORY read data
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              R0_REQ,
    input  logic              R0_LOCK,
    input  logic [ADDR_W-1:0] R0_A,
    input  logic              R0_WE,
    input  logic [DATA_W-1:0] R0_WDV,
    input  logic [DATA_W-1:0] R0_WDS,
    input  logic [1:0]        R0_POS,
    input  logic              R0_E,
    input  logic              R0_S,
    output logic              R0_GNT,
    output logic              R0_RVALID,
    output logic [DATA_W-1:0] R0_RD,

    input  logic              R1_REQ,
    input  logic              R1_LOCK,
    input  logic [ADDR_W-1:0] R1_A,
    input  logic              R1_WE,
    input  logic [DATA_W-1:0] R1_WDV,
    input  logic [DATA_W-1:0] R1_WDS,
    input  logic [1:0]        R1_POS,
    input  logic              R1_E,
    input  logic              R1_S,
    output logic              R1_GNT,
    output logic              R1_RVALID,
    output logic [DATA_W-1:0] R1_RD,

    output logic [ADDR_W-1:0] MEM_A,
    output logic [DATA_W-1:0] MEM_WDV,
    output logic [DATA_W-1:0] MEM_WDS,
    output logic [1:0]        MEM_POS,
    output logic              MEM_WE,
    output logic              MEM_E,
    output logic              MEM_S,
    input  logic [DATA_W-1:0] MEM_RD
);

    localparam int               CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               BURST_EN = (MAX_BURST > 1);

    arb_state_t       state, state_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             gnt0, gnt1;
    rd_tag_t          tag_push, tag_tail;

    assign cnt_inc = burst_cnt + CNT_ONE;

    // Grant decision; reset suppresses every grant.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST) begin
            unique case (state)
                IDLE: begin
                    if (R0_REQ && R1_REQ) begin
`ifdef ARB_FIXED_PRIO_EN
                        gnt0 = 1'b1;
`else
                        // Tie goes to whoever was not served last.
                        gnt0 = last;
                        gnt1 = ~last;
`endif
                    end else begin
                        gnt0 = R0_REQ;
                        gnt1 = R1_REQ;
                    end
                end
                OWN0:    gnt0 = R0_REQ;
                OWN1:    gnt1 = R1_REQ;
                default: ;
            endcase
        end
    end

    // Next state: burst entry, counting and exit. Leaving a burst records the owner
    // as last so the other requester wins the following tie.
    always_comb begin
        state_nxt     = state;
        last_nxt      = last;
        burst_cnt_nxt = burst_cnt;
        unique case (state)
            IDLE: begin
                if (gnt0) begin
                    last_nxt = 1'b0;
                    if (R0_LOCK && BURST_EN) begin
                        state_nxt     = OWN0;
                        burst_cnt_nxt = CNT_ONE;
                    end
                end else if (gnt1) begin
                    last_nxt = 1'b1;
                    if (R1_LOCK && BURST_EN) begin
                        state_nxt     = OWN1;
                        burst_cnt_nxt = CNT_ONE;
                    end
                end
            end
            OWN0: begin
                last_nxt = 1'b0;
                if (!R0_REQ || !R0_LOCK || cnt_inc == CNT_MAX) begin
                    state_nxt     = IDLE;
                    burst_cnt_nxt = '0;
                end else begin
                    burst_cnt_nxt = cnt_inc;
                end
            end
            OWN1: begin
                last_nxt = 1'b1;
                if (!R1_REQ || !R1_LOCK || cnt_inc == CNT_MAX) begin
                    state_nxt     = IDLE;
                    burst_cnt_nxt = '0;
                end else begin
                    burst_cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt     = IDLE;
                burst_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Memory-side mux; idle bus is driven to zero.
    always_comb begin
        MEM_A   = '0;
        MEM_WDV = '0;
        MEM_WDS = '0;
        MEM_POS = '0;
        MEM_WE  = 1'b0;
        MEM_E   = 1'b0;
        MEM_S   = 1'b0;
        if (gnt0) begin
            MEM_A   = R0_A;
            MEM_WDV = R0_WDV;
            MEM_WDS = R0_WDS;
            MEM_POS = R0_POS;
            MEM_WE  = R0_WE;
            MEM_E   = R0_E;
            MEM_S   = R0_S;
        end else if (gnt1) begin
            MEM_A   = R1_A;
            MEM_WDV = R1_WDV;
            MEM_WDS = R1_WDS;
            MEM_POS = R1_POS;
            MEM_WE  = R1_WE;
            MEM_E   = R1_E;
            MEM_S   = R1_S;
        end
    end

    assign R0_GNT = gnt0;
    assign R1_GNT = gnt1;

    assign tag_push.v  = (gnt0 & ~R0_WE) | (gnt1 & ~R1_WE);
    assign tag_push.id = gnt1;

    mem_arb_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk  (CLK),
        .rst  (RST),
        .push (tag_push),
        .tail (tag_tail)
    );

    // Reads still in flight while reset is asserted are dropped, including the one at the tail.
    assign R0_RVALID = tag_tail.v & ~tag_tail.id & ~RST;
    assign R1_RVALID = tag_tail.v &  tag_tail.id & ~RST;
    assign R0_RD     = MEM_RD;
    assign R1_RD     = MEM_RD;

endmodule
